// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_exec_unit_pkg;

    // Default operand/result width of the execute datapath.
    localparam int DATA_WIDTH_DEFAULT = 32;

    // ALU operation codes produced by the ALU control decoder.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;
    localparam logic [3:0] ALU_NOP = 4'd10;

    // Execute-unit control states.
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Iterative shift-add multiplier producing the low word of a*b.
// Latency: DATA_WIDTH step edges after start; product_o valid combinationally with done_o.
// Backpressure: none; the owner decides when to step or abort.
module seq_multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  step_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]      cnt_q;

    // Partial-product add for the current iteration; on the last step this is the product.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // Shift-add datapath and iteration counter; abort wipes any partial work.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (abort_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Counter wraps past the last step; done marks the edge that completes the product.
    assign cnt_o     = cnt_q;
    assign done_o    = step_i && (cnt_q == LAST_CNT);
    assign product_o = acc_d;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative multiply, registered result and flags.
// Latency: 1 edge for single-cycle ops, DATA_WIDTH+1 edges for mul.
// Backpressure: combinational stall holds upstream while a mul is accepted/in progress.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CNT_W      = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    input  logic [3:0]            in_alu_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [4:0]            in_shamt,
    input  logic                  in_flush,
    output logic                  stall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_neg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q;
    state_e                state_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  zero_q;
    logic                  zero_d;
    logic                  neg_q;
    logic                  neg_d;

    logic                  accept;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_step;
    logic                  mul_abort;
    logic                  mul_done;
    logic [CNT_W-1:0]      mul_cnt;
    logic [DATA_WIDTH-1:0] mul_product;
    logic [DATA_WIDTH-1:0] alu_res;

    assign is_mul    = (in_alu_op == ALU_MUL);
    assign accept    = (state_q == IDLE) && in_valid && !in_flush;
    assign mul_start = accept && is_mul;
    assign mul_step  = (state_q == MUL) && !in_flush;
    assign mul_abort = (state_q == MUL) && in_flush;

    seq_multiplier #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_mul (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .abort_i   (mul_abort),
        .a_i       (in_a),
        .b_i       (in_b),
        .cnt_o     (mul_cnt),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle result; nop and undefined codes yield zero so jumps still flow down the pipe.
    always_comb begin
        alu_res = '0;
        case (in_alu_op)
            ALU_ADD: alu_res = in_a + in_b;
            ALU_SUB: alu_res = in_a - in_b;
            ALU_AND: alu_res = in_a & in_b;
            ALU_OR:  alu_res = in_a | in_b;
            ALU_NOR: alu_res = ~(in_a | in_b);
            ALU_XOR: alu_res = in_a ^ in_b;
            ALU_SLL: alu_res = in_b << in_shamt;
            ALU_SRL: alu_res = in_b >> in_shamt;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: alu_res = '0;
        endcase
    end

    // Control FSM and result write-back; flags always follow the value being written.
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = MUL;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        neg_d    = alu_res[DATA_WIDTH-1];
                    end
                end
            end
            MUL: begin
                if (in_flush) begin
                    state_d = IDLE;
                end else if (mul_done) begin
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    neg_d    = mul_product[DATA_WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any multiply in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    // Hold upstream from the mul accept cycle until the final iteration edge.
    assign stall = !Reset &&
                   (((state_q == IDLE) && in_valid && is_mul && !in_flush) ||
                    ((state_q == MUL) && (mul_cnt < LAST_CNT)));

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases then randomized ops vs a reference model.
// Latency: checks 1-edge single-cycle results and 33-edge multiply results.
// Backpressure: drives stall-aware stimulus, holding mul inputs until the result appears.
module tb_alu_exec_unit;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic [3:0]  in_alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;
    logic        in_flush;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;

    int checks = 0;
    int fails  = 0;

    alu_exec_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_alu_op  (in_alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .in_flush   (in_flush),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour written straight from the op table with plain arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        longint unsigned prod;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: begin
                prod = longint'(a) * longint'(b);
                return prod[31:0];
            end
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return ~(a | b);
            4'd6: return a ^ b;
            4'd7: return b << sh;
            4'd8: return b >> sh;
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present one op, wait (bounded) for its result, then check result, flags and latency.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        logic [31:0] exp;
        int          n;
        exp       = model(op, a, b, sh);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        in_flush  = 1'b0;
        #1;
        check("stall_on_present", {31'd0, stall}, (op == 4'd2) ? 32'd1 : 32'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 40);
        in_valid = 1'b0;
        check("op_latency", n, (op == 4'd2) ? 32'd33 : 32'd1);
        check("op_valid", {31'd0, out_valid}, 32'd1);
        check("op_result", out_result, exp);
        check("op_zero", {31'd0, out_zero}, (exp == 32'd0) ? 32'd1 : 32'd0);
        check("op_neg", {31'd0, out_neg}, {31'd0, exp[31]});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        logic [4:0]  rsh;
        logic [31:0] held;

        // Reset state, including stall forced low even with a mul on the inputs.
        Reset     = 1'b1;
        in_valid  = 1'b1;
        in_alu_op = 4'd2;
        in_a      = 32'd3;
        in_b      = 32'd4;
        in_shamt  = 5'd0;
        in_flush  = 1'b0;
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_zero", {31'd0, out_zero}, 32'd0);
        check("rst_neg", {31'd0, out_neg}, 32'd0);
        in_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // add overflow wraps to negative, then the result holds with valid low.
        do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        step();
        check("add_valid_drop", {31'd0, out_valid}, 32'd0);
        check("add_result_hold", out_result, 32'h8000_0000);
        check("add_neg_hold", {31'd0, out_neg}, 32'd1);

        // sub to zero, signed compares, shift boundaries, back to back.
        do_op(4'd1, 32'd5, 32'd5, 5'd0);
        do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op(4'd9, 32'd1, 32'hFFFF_FFFF, 5'd0);
        do_op(4'd7, 32'hDEAD_BEEF, 32'd1, 5'd31);
        do_op(4'd8, 32'h0, 32'h8000_0000, 5'd31);
        do_op(4'd7, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0);
        do_op(4'd5, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);

        // mul -3 * 7 with stall profile checked edge by edge, then an add right behind it.
        in_valid  = 1'b1;
        in_alu_op = 4'd2;
        in_a      = 32'hFFFF_FFFD;
        in_b      = 32'd7;
        #1;
        check("mul_stall_accept", {31'd0, stall}, 32'd1);
        step();
        check("mul_e0_valid", {31'd0, out_valid}, 32'd0);
        check("mul_e0_stall", {31'd0, stall}, 32'd1);
        for (int k = 1; k <= 31; k++) begin
            step();
            check("mul_no_early_valid", {31'd0, out_valid}, 32'd0);
            check("mul_stall_profile", {31'd0, stall}, (k < 31) ? 32'd1 : 32'd0);
        end
        step();
        check("mul_valid", {31'd0, out_valid}, 32'd1);
        check("mul_result", out_result, 32'hFFFF_FFEB);
        check("mul_neg", {31'd0, out_neg}, 32'd1);
        in_alu_op = 4'd0;
        in_a      = 32'd2;
        in_b      = 32'd3;
        #1;
        check("post_mul_stall", {31'd0, stall}, 32'd0);
        step();
        in_valid = 1'b0;
        check("post_mul_add_valid", {31'd0, out_valid}, 32'd1);
        check("post_mul_add_result", out_result, 32'd5);

        // Flush in IDLE blocks acceptance.
        in_valid  = 1'b1;
        in_flush  = 1'b1;
        in_alu_op = 4'd0;
        in_a      = 32'd100;
        in_b      = 32'd1;
        step();
        in_valid = 1'b0;
        in_flush = 1'b0;
        check("flush_idle_valid", {31'd0, out_valid}, 32'd0);
        check("flush_idle_result", out_result, 32'd5);

        // Flush a mul at counter=5: no result, back in IDLE.
        held      = out_result;
        in_valid  = 1'b1;
        in_alu_op = 4'd2;
        in_a      = 32'd9;
        in_b      = 32'd9;
        step();
        for (int k = 0; k < 5; k++) step();
        in_flush = 1'b1;
        step();
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", out_result, held);
        in_flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_idle_stall", {31'd0, stall}, 32'd0);
        step();
        check("abort_no_late_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result_hold", out_result, held);

        // Reset pulse at counter=10 clears outputs immediately; a fresh mul then completes.
        in_valid  = 1'b1;
        in_alu_op = 4'd2;
        in_a      = 32'd1234;
        in_b      = 32'd5678;
        step();
        for (int k = 0; k < 10; k++) step();
        Reset = 1'b1;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_result", out_result, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_zero", {31'd0, out_zero}, 32'd0);
        step();
        Reset = 1'b0;
        do_op(4'd2, 32'h0001_0003, 32'h0002_0005, 5'd0);

        // nop and undefined codes still pulse valid with a zero result.
        do_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        do_op(4'd15, 32'h1234_5678, 32'h8765_4321, 5'd7);

        // Randomized back-to-back ops against the model.
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            if ((i % 7) == 0) rb = ra;
            do_op(rop, ra, rb, rsh);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the register operands and the shift amount.
- Single-cycle ops produce a registered result one clock after acceptance.
- `mul` runs on an iterative shift-add multiplier and stalls upstream until the product is ready.
- Output feeds the EX/MEM boundary; zero/negative flags feed branch resolution.

Parameters:
DATA_WIDTH, 32, operand/result width; multiplier iteration count equals DATA_WIDTH.
CNT_W, 5, multiplier iteration counter width (clog2(DATA_WIDTH)).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation present on inputs this cycle
in_alu_op  input  4  0 add, 1 sub, 2 mul, 3 and, 4 or, 5 nor, 6 xor, 7 sll, 8 srl, 9 slt, 10 nop
in_a  input  DATA_WIDTH  rs operand
in_b  input  DATA_WIDTH  rt operand / immediate
in_shamt  input  5  shift amount for sll/srl
in_flush  input  1  synchronous kill of in-flight and incoming op
stall  output  1  upstream must hold its inputs (combinational)
out_valid  output  1  one-cycle pulse: result registers updated
out_result  output  DATA_WIDTH  registered result
out_zero  output  1  registered (out_result == 0)
out_neg  output  1  registered out_result[DATA_WIDTH-1]

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, multiplier regs=0, out_valid=0, out_result=0, out_zero=0, out_neg=0; a multiply in progress is abandoned. stall=0 while Reset is high.
- States: IDLE, MUL.
- Acceptance: in IDLE, with in_valid=1 and in_flush=0, the inputs are accepted at the clock edge (edge E0).
- Single-cycle ops (all codes except 2): result written at E0; out_valid=1 for the cycle after E0; latency 1.
  - add/sub: modulo 2^DATA_WIDTH wraparound; no overflow trap.
  - and/or/nor/xor: bitwise.
  - sll/srl: in_b shifted by in_shamt (logical, zero fill); in_a is ignored.
  - slt: signed compare of in_a < in_b; result 1 or 0, zero-extended.
  - nop (10) and undefined codes 11-15: result 0, out_zero=1, out_valid still pulses so j/jal flow down the pipe.
- Flags: out_zero and out_neg are always derived from the value written to out_result in the same edge.
- Between results: out_result and the flags hold their last value while out_valid=0.
- mul (code 2):
  - At E0: load multiplicand=in_a, multiplier=in_b, accumulator=0, counter=0; go to MUL.
  - Each edge E1..E32: if multiplier LSB=1, add multiplicand to accumulator; shift multiplicand left 1 and multiplier right 1; counter+1.
  - At E32: the low DATA_WIDTH bits of the accumulator (the signed/unsigned low word is identical) are written to out_result; out_valid=1 in the cycle after E32; state returns to IDLE.
- stall = (IDLE & in_valid & op==2 & !in_flush) | (MUL & counter < DATA_WIDTH-1).
  - Upstream holds the mul through edge E31 and advances at E32.
  - The instruction presented after E32 is seen in IDLE.
  - Inputs are never sampled while in MUL.
- in_flush:
  - In IDLE: no acceptance; out_valid=0 next cycle.
  - In MUL: return to IDLE at the next edge; no out_valid; out_result is unchanged.
  - in_flush has priority over in_valid.
- Back-to-back single-cycle ops: one accepted per clock, never stalled.

Decomposition:
- Shared package:
  - ALU op code constants ALU_ADD..ALU_NOP (values 0-10), shared with the ALU control decoder.
  - State enum IDLE/MUL.
  - DATA_WIDTH default.
- One sub-module: seq_multiplier.
  - Contents: shift-add datapath, counter, start/done/abort ports.
  - alu_exec_unit owns the FSM, stall, combinational ops and output registers.

Test Plan:
- add: a=0x7FFFFFFF, b=0x00000001 -> after 1 edge out_result=0x80000000, out_valid=1 for one cycle, zero=0, neg=1.
- sub/slt: sub a=5, b=5 -> result 0, zero=1. slt a=0xFFFFFFFF, b=1 -> 1. slt a=1, b=0xFFFFFFFF -> 0.
- shifts: sll b=1, shamt=31 -> 0x80000000. srl b=0x80000000, shamt=31 -> 0x00000001. sll with shamt=0 -> b unchanged.
- mul: a=0xFFFFFFFD (-3), b=7 -> out_result=0xFFFFFFEB, out_valid only after E32. stall high from the accept cycle while counter<31, low at counter=31. Then an add (2+3) is presented; its result 5 arrives one edge after acceptance.
- abort: flush at counter=5 -> no out_valid, IDLE next cycle, out_result unchanged. Reset pulse at counter=10 -> all outputs 0 immediately, stall=0; a new mul afterwards completes correctly.
- nop/undefined: ops 10 and 15 -> out_valid pulses, result 0, zero=1, no stall.
